// File: rtl/softmax_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_divider: alpha = dividend / sum in unsigned Q1.31, bit-serial      |
// | restoring divider feeding the alpha FIFO. Option: SOFTMAX_ROUND_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module softmax_divider #(
   parameter int SM_DATA_WIDTH     = 108,
   parameter int SM_SUM_DATA_WIDTH = 108,
   parameter int ALPHA_DATA_WIDTH  = 32,
   parameter int MAX_NODES         = 168,
   localparam int NUM_NODE_WIDTH   = $clog2(MAX_NODES)
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [SM_DATA_WIDTH-1:0]                    dividend_ff_dout,
   input  logic                                        dividend_ff_empty,
   output logic                                        dividend_ff_rd_vld,
   input  logic [NUM_NODE_WIDTH+SM_SUM_DATA_WIDTH-1:0] divisor_ff_dout,
   input  logic                                        divisor_ff_empty,
   output logic                                        divisor_ff_rd_vld,
   output logic [ALPHA_DATA_WIDTH-1:0]                 alpha_ff_din,
   output logic                                        alpha_ff_wr_vld,
   input  logic                                        alpha_ff_full,
   output logic                                        subgraph_done,
   output logic                                        busy
);

`ifdef SOFTMAX_ROUND_EN
   localparam int C_ITER = ALPHA_DATA_WIDTH + 1;
`else
   localparam int C_ITER = ALPHA_DATA_WIDTH;
`endif
   localparam int C_CNT_W = $clog2(C_ITER + 1);
   localparam int C_REM_W = SM_SUM_DATA_WIDTH + 1;
   localparam int C_CMP_W = ((SM_DATA_WIDTH > C_REM_W) ? SM_DATA_WIDTH : C_REM_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_DIV = 2'd1,
      S_DIVIDE   = 2'd2,
      S_OUT      = 2'd3
   } state_t;

   state_t                        r_state;
   logic [SM_SUM_DATA_WIDTH-1:0]  r_sum;
   logic [NUM_NODE_WIDTH-1:0]     r_num_node;
   logic [NUM_NODE_WIDTH-1:0]     r_node_cnt;
   logic [C_REM_W-1:0]            r_rem;
   logic [C_ITER-2:0]             r_quot;
   logic [C_CNT_W-1:0]            r_bit_cnt;
   logic                          r_special;
   logic [ALPHA_DATA_WIDTH-1:0]   r_special_val;
   logic [ALPHA_DATA_WIDTH-1:0]   r_alpha;
   logic                          r_done;

   logic [SM_SUM_DATA_WIDTH-1:0]  w_div_sum;
   logic [NUM_NODE_WIDTH-1:0]     w_div_num;
   logic [C_REM_W-1:0]            w_sum_ext;
   logic                          w_q_bit;
   logic [C_REM_W-1:0]            w_rem_sub;
   logic [C_ITER-1:0]             w_quot_nxt;
   logic [ALPHA_DATA_WIDTH-1:0]   w_result;
   logic [C_CMP_W-1:0]            w_dividend_ext;
   logic [C_CMP_W-1:0]            w_two_sum;
   logic [NUM_NODE_WIDTH-1:0]     w_node_cnt_nxt;

   assign w_div_sum      = divisor_ff_dout[SM_SUM_DATA_WIDTH-1:0];
   assign w_div_num      = divisor_ff_dout[NUM_NODE_WIDTH+SM_SUM_DATA_WIDTH-1:SM_SUM_DATA_WIDTH];
   assign w_sum_ext      = {1'b0, r_sum};
   assign w_q_bit        = (r_rem >= w_sum_ext);
   assign w_rem_sub      = r_rem - (w_q_bit ? w_sum_ext : '0);
   assign w_quot_nxt     = {r_quot, w_q_bit};
   assign w_dividend_ext = C_CMP_W'(dividend_ff_dout);
   assign w_two_sum      = C_CMP_W'({r_sum, 1'b0});
   assign w_node_cnt_nxt = r_node_cnt + 1'b1;

`ifdef SOFTMAX_ROUND_EN
   // Guard bit rounds half-up; a carry out of the top means the result saturates.
   logic [ALPHA_DATA_WIDTH:0] w_rounded;
   assign w_rounded = {1'b0, w_quot_nxt[C_ITER-1:1]} + {{ALPHA_DATA_WIDTH{1'b0}}, w_quot_nxt[0]};
   assign w_result  = w_rounded[ALPHA_DATA_WIDTH] ? '1 : w_rounded[ALPHA_DATA_WIDTH-1:0];
`else
   assign w_result  = w_quot_nxt;
`endif

   // Strobes are suppressed while reset is sampled so nothing is popped or pushed then.
   assign divisor_ff_rd_vld  = !rst_n && (r_state == S_IDLE)     && !divisor_ff_empty;
   assign dividend_ff_rd_vld = !rst_n && (r_state == S_WAIT_DIV) && !dividend_ff_empty;
   assign alpha_ff_wr_vld    = !rst_n && (r_state == S_OUT)      && !alpha_ff_full;
   assign alpha_ff_din       = r_alpha;
   assign subgraph_done      = r_done;
   assign busy               = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state       <= S_IDLE;
         r_sum         <= '0;
         r_num_node    <= '0;
         r_node_cnt    <= '0;
         r_rem         <= '0;
         r_quot        <= '0;
         r_bit_cnt     <= '0;
         r_special     <= 1'b0;
         r_special_val <= '0;
         r_alpha       <= '0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (divisor_ff_rd_vld) begin
                  r_sum      <= w_div_sum;
                  r_num_node <= w_div_num;
                  r_node_cnt <= '0;
                  if (w_div_num == '0) r_done  <= 1'b1;
                  else                 r_state <= S_WAIT_DIV;
               end
            end
            S_WAIT_DIV: begin
               if (dividend_ff_rd_vld) begin
                  r_bit_cnt <= '0;
                  r_quot    <= '0;
                  r_state   <= S_DIVIDE;
                  // Special cases still sit through the full iteration count.
                  if (r_sum == '0) begin
                     r_special     <= 1'b1;
                     r_special_val <= '0;
                     r_rem         <= '0;
                  end else if (w_dividend_ext >= w_two_sum) begin
                     r_special     <= 1'b1;
                     r_special_val <= '1;
                     r_rem         <= '0;
                  end else begin
                     r_special     <= 1'b0;
                     r_special_val <= '0;
                     r_rem         <= C_REM_W'(dividend_ff_dout);
                  end
               end
            end
            S_DIVIDE: begin
               r_rem     <= w_rem_sub << 1;
               r_quot    <= w_quot_nxt[C_ITER-2:0];
               r_bit_cnt <= r_bit_cnt + 1'b1;
               if (r_bit_cnt == C_CNT_W'(C_ITER - 1)) begin
                  r_alpha <= r_special ? r_special_val : w_result;
                  r_state <= S_OUT;
               end
            end
            S_OUT: begin
               if (alpha_ff_wr_vld) begin
                  r_node_cnt <= w_node_cnt_nxt;
                  if (w_node_cnt_nxt == r_num_node) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_WAIT_DIV;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_softmax_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_softmax_divider: directed bench for softmax_divider with a cycle model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_softmax_divider;
   localparam int DW = 108;
   localparam int SW = 108;
   localparam int AW = 32;
   localparam int MN = 168;
   localparam int NW = $clog2(MN);
`ifdef SOFTMAX_ROUND_EN
   localparam int LAT = AW + 2;
`else
   localparam int LAT = AW + 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] dividend_ff_dout;
   logic          dividend_ff_empty;
   logic          dividend_ff_rd_vld;
   logic [NW+SW-1:0] divisor_ff_dout;
   logic          divisor_ff_empty;
   logic          divisor_ff_rd_vld;
   logic [AW-1:0] alpha_ff_din;
   logic          alpha_ff_wr_vld;
   logic          alpha_ff_full = 1'b0;
   logic          subgraph_done;
   logic          busy;

   always #5 clk = ~clk;

   softmax_divider #(
      .SM_DATA_WIDTH(DW), .SM_SUM_DATA_WIDTH(SW), .ALPHA_DATA_WIDTH(AW), .MAX_NODES(MN)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .dividend_ff_dout(dividend_ff_dout), .dividend_ff_empty(dividend_ff_empty),
      .dividend_ff_rd_vld(dividend_ff_rd_vld),
      .divisor_ff_dout(divisor_ff_dout), .divisor_ff_empty(divisor_ff_empty),
      .divisor_ff_rd_vld(divisor_ff_rd_vld),
      .alpha_ff_din(alpha_ff_din), .alpha_ff_wr_vld(alpha_ff_wr_vld),
      .alpha_ff_full(alpha_ff_full), .subgraph_done(subgraph_done), .busy(busy)
   );

   logic [DW-1:0]    q_dvd[$];
   logic [NW+SW-1:0] q_dvs[$];
   logic [AW-1:0]    got_log[$];
   int               lat_log[$];
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   logic pop_dvd = 1'b0;
   logic pop_dvs = 1'b0;

   // Model state
   logic m_active = 1'b0, m_want = 1'b0, m_pending = 1'b0, m_done = 1'b0;
   int   m_ready = 0, m_pop_cyc = 0, m_left = 0;
   logic [SW-1:0] m_sum = '0;
   logic [AW-1:0] m_exp = '0;
   logic e_dvs, e_dvd, e_wr, new_done;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic refresh();
      dividend_ff_empty = (q_dvd.size() == 0);
      dividend_ff_dout  = dividend_ff_empty ? '0 : q_dvd[0];
      divisor_ff_empty  = (q_dvs.size() == 0);
      divisor_ff_dout   = divisor_ff_empty ? '0 : q_dvs[0];
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%08h exp=%08h", name, cyc, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout at cyc=%0d", name, cyc);
   endtask

   // Reference quotient straight from the arithmetic definition of alpha.
   function automatic logic [AW-1:0] model_alpha(input logic [DW-1:0] d, input logic [SW-1:0] s);
      logic [255:0] dd, ss, q;
      dd = 256'(d);
      ss = 256'(s);
      if (ss == 0) return '0;
      if (dd >= 2 * ss) return '1;
`ifdef SOFTMAX_ROUND_EN
      q = (dd << AW) / ss;
      q = (q + 1) >> 1;
      if (q[AW]) return '1;
`else
      q = (dd << (AW - 1)) / ss;
`endif
      return q[AW-1:0];
   endfunction

   // FIFO models: pops decided at the previous falling edge take effect just after the rising edge.
   initial begin
      refresh();
      forever begin
         @(posedge clk);
         #1;
         if (pop_dvd && q_dvd.size() > 0) void'(q_dvd.pop_front());
         if (pop_dvs && q_dvs.size() > 0) void'(q_dvs.pop_front());
         refresh();
      end
   end

   // Compare process: every cycle, every output against the model.
   always @(negedge clk) begin
      e_dvs = !rst_n && !m_active && !divisor_ff_empty;
      e_dvd = !rst_n && m_want && !dividend_ff_empty;
      e_wr  = !rst_n && m_pending && (cyc >= m_ready) && !alpha_ff_full;
      chk1("divisor_rd", divisor_ff_rd_vld, e_dvs);
      chk1("dividend_rd", dividend_ff_rd_vld, e_dvd);
      chk1("wr_vld", alpha_ff_wr_vld, e_wr);
      chk1("busy", busy, m_active);
      chk1("subgraph_done", subgraph_done, m_done);
      if (m_pending && cyc >= m_ready) chk32("alpha_din", alpha_ff_din, m_exp);

      pop_dvs = divisor_ff_rd_vld && !divisor_ff_empty;
      pop_dvd = dividend_ff_rd_vld && !dividend_ff_empty;
      if (subgraph_done) n_done++;
      if (alpha_ff_wr_vld) begin
         got_log.push_back(alpha_ff_din);
         lat_log.push_back(cyc - m_pop_cyc);
      end

      new_done = 1'b0;
      if (rst_n) begin
         m_active = 1'b0; m_want = 1'b0; m_pending = 1'b0;
      end else begin
         if (e_dvs) begin
            m_sum = divisor_ff_dout[SW-1:0];
            m_left = int'(divisor_ff_dout[NW+SW-1:SW]);
            if (m_left == 0) new_done = 1'b1;
            else begin m_active = 1'b1; m_want = 1'b1; end
         end
         if (e_dvd) begin
            m_want = 1'b0;
            m_pending = 1'b1;
            m_pop_cyc = cyc;
            m_ready = cyc + LAT;
            m_exp = model_alpha(dividend_ff_dout, m_sum);
         end
         if (e_wr) begin
            m_pending = 1'b0;
            m_left--;
            if (m_left == 0) begin m_active = 1'b0; new_done = 1'b1; end
            else m_want = 1'b1;
         end
      end
      m_done = new_done;
   end

   task automatic add_sg(input logic [SW-1:0] s, input int n);
      q_dvs.push_back({NW'(n), s});
      refresh();
   endtask

   task automatic add_dvd(input logic [DW-1:0] d);
      q_dvd.push_back(d);
      refresh();
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (!m_active && !m_pending && !m_done && q_dvs.size() == 0 && q_dvd.size() == 0) return;
      end
      timeout(name);
   endtask

   task automatic wait_pending(input string name);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (m_pending) return;
      end
      timeout(name);
   endtask

   task automatic wait_cyc(input int target);
      for (int i = 0; i < 200; i++) begin
         if (cyc >= target) return;
         @(posedge clk);
         #1;
      end
   endtask

   int b;
   int d0;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_wr", alpha_ff_wr_vld, 1'b0);
      chk32("rst_din", alpha_ff_din, 32'h0);
      chk1("rst_done", subgraph_done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;

      // Basic two-node subgraph
      b = got_log.size(); d0 = n_done;
      add_sg(108'd4, 2); add_dvd(108'd1); add_dvd(108'd3);
      wait_idle("basic");
      chk32("basic0", got_log[b], 32'h2000_0000);
      chk32("basic1", got_log[b+1], 32'h6000_0000);
      chk32("basic_lat", 32'(lat_log[b]), 32'(LAT));
      chk32("basic_done_cnt", 32'(n_done - d0), 32'd1);

      // Unity
      b = got_log.size();
      add_sg(108'd7, 1); add_dvd(108'd7);
      wait_idle("unity");
      chk32("unity", got_log[b], 32'h8000_0000);

      // Saturation boundary: 9 and 8 saturate, 7 is just below 2*sum
      b = got_log.size();
      add_sg(108'd4, 3); add_dvd(108'd9); add_dvd(108'd8); add_dvd(108'd7);
      wait_idle("sat");
      chk32("sat9", got_log[b], 32'hFFFF_FFFF);
      chk32("sat8", got_log[b+1], 32'hFFFF_FFFF);
      chk32("sat7", got_log[b+2], 32'hE000_0000);

      // Zero sum
      b = got_log.size();
      add_sg(108'd0, 1); add_dvd(108'd5);
      wait_idle("zero_sum");
      chk32("zero_sum", got_log[b], 32'h0);

      // Rounding
      b = got_log.size();
      add_sg(108'd3, 1); add_dvd(108'd1);
      wait_idle("round");
`ifdef SOFTMAX_ROUND_EN
      chk32("round", got_log[b], 32'h2AAA_AAAB);
`else
      chk32("round", got_log[b], 32'h2AAA_AAAA);
`endif
      chk32("round_lat", 32'(lat_log[b]), 32'(LAT));

      // Wide operands
      add_sg({SW{1'b1}}, 2); add_dvd({DW{1'b1}}); add_dvd({1'b1, {(DW-1){1'b0}}});
      wait_idle("wide");

      // Zero-node subgraph followed by a normal one
      b = got_log.size(); d0 = n_done;
      add_sg(108'd123, 0); add_sg(108'd8, 1); add_dvd(108'd6);
      wait_idle("zero_node");
      chk32("zero_node_alpha", got_log[b], 32'h6000_0000);
      chk32("zero_node_done_cnt", 32'(n_done - d0), 32'd2);

      // Backpressure for 10 cycles on OUT entry
      b = got_log.size();
      add_sg(108'd10, 2); add_dvd(108'd3); add_dvd(108'd7);
      wait_pending("bp_pop");
      wait_cyc(m_ready);
      alpha_ff_full = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      alpha_ff_full = 1'b0;
      wait_idle("bp");
      chk32("bp_alpha", got_log[b], 32'h2666_6666);
      chk32("bp_lat", 32'(lat_log[b]), 32'(LAT + 10));
      chk32("bp_count", 32'(got_log.size() - b), 32'd2);

      // Reset during DIVIDE cycle 10
      b = got_log.size();
      add_sg(108'd5, 1); add_dvd(108'd3);
      wait_pending("rst_pop");
      wait_cyc(m_pop_cyc + 10);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_wr", alpha_ff_wr_vld, 1'b0);
      chk32("mid_rst_din", alpha_ff_din, 32'h0);
      chk1("mid_rst_done", subgraph_done, 1'b0);
      repeat (60) @(posedge clk);
      #1;
      chk32("mid_rst_no_push", 32'(got_log.size() - b), 32'd0);

      // Recovery after reset
      b = got_log.size();
      add_sg(108'd4, 1); add_dvd(108'd2);
      wait_idle("recover");
      chk32("recover", got_log[b], 32'h4000_0000);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
